// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver: circular store of {break, data}
// entries, presented oldest-first on a valid/ready port, with a sticky overflow flag.
module uart_rx_fifo #(
    parameter  int PAYLOAD_BITS = 8,
    parameter  int DEPTH        = 16,
    localparam int CW           = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [PAYLOAD_BITS-1:0] in_data,
    input  logic                    in_break,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PAYLOAD_BITS-1:0] out_data,
    output logic                    out_break,
    output logic [CW-1:0]           count,
    output logic                    empty,
    output logic                    full,
    output logic                    overflow,
    input  logic                    overflow_clear
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = PAYLOAD_BITS + 1;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          push;
    logic          pop;
    logic          drop;
    logic [EW-1:0] head;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        if (ptr == AW'(DEPTH - 1))
            return '0;
        else
            return ptr + AW'(1);
    endfunction

    function automatic logic [CW-1:0] count_next(input logic [CW-1:0] cur,
                                                 input logic          do_push,
                                                 input logic          do_pop);
        logic [CW-1:0] nxt;
        nxt = cur;
        if (do_push && !do_pop && cur != CW'(DEPTH))
            nxt = cur + CW'(1);
        else if (do_pop && !do_push && cur != '0)
            nxt = cur - CW'(1);
        return nxt;
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign out_valid = !empty;

    assign pop  = out_valid & out_ready;
    // A full buffer still takes a byte when the head leaves in the same cycle.
    assign push = in_valid & (!full | pop);
    assign drop = in_valid & full & !pop;

    assign head      = mem[rp];
    assign out_data  = empty ? '0 : head[PAYLOAD_BITS-1:0];
    assign out_break = empty ? 1'b0 : head[PAYLOAD_BITS];

    always_ff @(posedge clk) begin
        if (push)
            mem[wp] <= {in_break, in_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wp <= ptr_inc(wp);
            if (pop)
                rp <= ptr_inc(rp);
            count <= count_next(count, push, pop);
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop)
                overflow <= 1'b1;
            else if (overflow_clear)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected entries, a negedge
// monitor pops and compares every entry the DUT hands over.
module tb_uart_rx_fifo;

    localparam int PB    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [PB-1:0] in_data;
    logic          in_break;
    logic          out_valid;
    logic          out_ready;
    logic [PB-1:0] out_data;
    logic          out_break;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          overflow_clear;

    int n_checks = 0;
    int n_fails  = 0;
    logic [PB:0] exp_q [$];

    uart_rx_fifo #(.PAYLOAD_BITS(PB), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_break(in_break),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_break(out_break),
        .count(count), .empty(empty), .full(full),
        .overflow(overflow), .overflow_clear(overflow_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [PB-1:0] d, input logic b, input bit accept);
        in_valid = 1'b1;
        in_data  = d;
        in_break = b;
        step();
        in_valid = 1'b0;
        in_data  = '0;
        in_break = 1'b0;
        if (accept)
            exp_q.push_back({b, d});
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (empty)
                break;
            step();
        end
        out_ready = 1'b0;
        check({name, "_drained"}, 32'(empty), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"},  32'(out_data),  32'd0);
        check({tag, "_out_break"}, 32'(out_break), 32'd0);
        check({tag, "_count"},     32'(count),     32'd0);
        check({tag, "_empty"},     32'(empty),     32'd1);
        check({tag, "_full"},      32'(full),      32'd0);
        check({tag, "_overflow"},  32'(overflow),  32'd0);
    endtask

    // Monitor: head is consumed at the next rising edge whenever valid & ready here.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check("valid_vs_model", 32'(out_valid), 32'(exp_q.size() != 0));
            if (!out_valid) begin
                check("empty_data_zero", {23'd0, out_break, out_data}, 32'd0);
            end else if (out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 32'd1, 32'd0);
                end else begin
                    logic [PB:0] e;
                    e = exp_q.pop_front();
                    check("pop_entry", {23'd0, out_break, out_data}, 32'(e));
                end
            end
        end
    end

    initial begin
        reset          = 1'b1;
        in_valid       = 1'b0;
        in_data        = '0;
        in_break       = 1'b0;
        out_ready      = 1'b0;
        overflow_clear = 1'b0;
        #1;
        check_reset_outputs("rst0");
        step();
        step();
        reset = 1'b0;
        step();

        // Basic push then ordered drain
        push_byte(8'h41, 1'b0, 1'b1);
        check("first_latency_valid", 32'(out_valid), 32'd1);
        push_byte(8'h42, 1'b0, 1'b1);
        push_byte(8'h43, 1'b0, 1'b1);
        check("basic_count", 32'(count), 32'd3);
        check("basic_head", 32'(out_data), 32'h41);
        check("basic_valid", 32'(out_valid), 32'd1);
        drain("basic");
        check("basic_empty_data", 32'(out_data), 32'd0);

        // Fill, drop, drain
        for (int i = 0; i < DEPTH; i++)
            push_byte(8'(i), 1'b0, 1'b1);
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd16);
        check("fill_no_ovf", 32'(overflow), 32'd0);
        push_byte(8'hAA, 1'b0, 1'b0);
        check("drop_overflow", 32'(overflow), 32'd1);
        check("drop_count", 32'(count), 32'd16);
        drain("drop");
        check("drop_ovf_sticky", 32'(overflow), 32'd1);
        overflow_clear = 1'b1;
        step();
        overflow_clear = 1'b0;
        check("clear_overflow", 32'(overflow), 32'd0);

        // Push while full with simultaneous pop
        for (int i = 0; i < DEPTH; i++)
            push_byte(8'h10 + 8'(i), 1'b0, 1'b1);
        in_valid  = 1'b1;
        in_data   = 8'h55;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 8'h55});
        check("fullpp_count", 32'(count), 32'd16);
        check("fullpp_no_ovf", 32'(overflow), 32'd0);
        drain("fullpp");

        // Streaming push/pop across pointer wrap, one BREAK entry
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == 20)
                push_byte(8'h00, 1'b1, 1'b1);
            else
                push_byte(8'(i * 7 + 3), 1'b0, 1'b1);
        end
        check("stream_count", 32'(count), 32'd1);
        drain("stream");

        // Clear, then drop colliding with clear
        for (int i = 0; i < DEPTH; i++)
            push_byte(8'h80 + 8'(i), 1'b0, 1'b1);
        push_byte(8'hEE, 1'b0, 1'b0);
        check("coll_set", 32'(overflow), 32'd1);
        overflow_clear = 1'b1;
        step();
        overflow_clear = 1'b0;
        check("coll_cleared", 32'(overflow), 32'd0);
        overflow_clear = 1'b1;
        push_byte(8'hEF, 1'b0, 1'b0);
        overflow_clear = 1'b0;
        check("coll_set_wins", 32'(overflow), 32'd1);

        // Reset mid-operation
        out_ready = 1'b1;
        repeat (11) step();
        out_ready = 1'b0;
        check("mid_count", 32'(count), 32'd5);
        check("mid_overflow", 32'(overflow), 32'd1);
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        exp_q.delete();
        step();
        reset = 1'b0;
        push_byte(8'h7E, 1'b0, 1'b1);
        check("post_rst_count", 32'(count), 32'd1);
        check("post_rst_head", 32'(out_data), 32'h7E);
        drain("post_rst");
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each single-cycle received-byte pulse, together with its BREAK flag, into a circular buffer. It presents the oldest entry to the host logic over a valid/ready interface. Bytes arriving while the buffer is full are dropped and reported through a sticky overflow flag, so the receiver never has to stall.

## Interface
- PAYLOAD_BITS, 8, width of each stored data byte; must match the receiver payload width.
- DEPTH, 16, number of entries; power of two, >= 2.
- CW (localparam), $clog2(DEPTH)+1, width of the occupancy count.

- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  single-cycle pulse: received byte available (from receiver valid).
- in_data  input  PAYLOAD_BITS  received byte, sampled when in_valid=1.
- in_break  input  1  received frame was a BREAK, sampled when in_valid=1.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts the head entry this cycle.
- out_data  output  PAYLOAD_BITS  head entry data.
- out_break  output  1  head entry BREAK flag.
- count  output  CW  number of stored entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: at least one byte was dropped.
- overflow_clear  input  1  clears overflow.

## Operation
- Storage is DEPTH entries of {in_break, in_data}, plus write pointer wp, read pointer rp (each $clog2(DEPTH) bits), and registered count.
- The storage array is not reset. Pointers, count and flags are reset.
- The block has no FSM. State is fully described by count: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
- Pop:
  - pop = out_valid & out_ready.
  - rp increments, wrapping DEPTH-1 -> 0.
  - out_ready while out_valid=0 is ignored.
- Push:
  - push = in_valid & (!full | pop).
  - Data is written at wp, then wp increments and wraps DEPTH-1 -> 0.
  - When full, a push is still accepted if a pop occurs in the same cycle.
- Drop: in_valid & full & !pop.
  - The byte is discarded. Pointers and count are unchanged.
  - overflow is set on the next edge.
- Count update:
  - push & !pop: count + 1.
  - pop & !push: count - 1.
  - Both or neither: unchanged.
  - count never exceeds DEPTH and never underflows.
- overflow:
  - Set by a drop; cleared by overflow_clear.
  - If a drop and overflow_clear occur in the same cycle, set wins.
- Outputs:
  - out_valid = !empty.
  - out_data = mem[rp] and out_break = break bit at rp, both forced to 0 when empty.
- BREAK entries are stored and delivered like any other byte: data 0, out_break=1. The block does not filter them.
- in_valid is assumed to be at most one cycle per received frame. Back-to-back in_valid pulses on consecutive cycles must still each be handled correctly.

## Timing
- Reset values (asynchronous, immediate on reset=1):
  - out_valid=0, out_data=0, out_break=0.
  - count=0, empty=1, full=0, overflow=0.
  - wp=0, rp=0.
- Reset mid-operation discards all stored entries and clears overflow. The first in_valid after reset deassertion is accepted normally.
- Write-to-read latency:
  - A byte pushed at edge N appears on out_data with out_valid=1 after edge N (cycle N+1).
  - There is no combinational path from in_* to out_*.
- Pop latency: after a pop at edge N, the next entry (or out_valid=0) is presented in cycle N+1.
- Flag timing: empty, full and count are registered or derived from registered count, and change only after a clock edge.
- overflow rises in the cycle after the drop edge, and falls in the cycle after the overflow_clear edge.
- Sustained throughput is one push and one pop per cycle simultaneously.

## Test plan
- Basic push: after reset, push 0x41, 0x42, 0x43 on separate cycles with out_ready=0 -> count=3, out_data=0x41, out_valid=1. Then hold out_ready=1 -> 0x41, 0x42, 0x43 in order, then empty=1, out_data=0.
- Full and drop: push DEPTH bytes 0x00..0x0F -> full=1. Push 0xAA -> dropped, overflow=1 next cycle, count stays 16. Drain -> 0x00..0x0F with no 0xAA.
- Push while full with pop: at full, assert in_valid=0x55 and out_ready=1 together -> count stays 16, overflow stays 0. 0x55 emerges last after draining.
- Wrap-around and BREAK: run 40 push/pop pairs with pointer wrap; include in_data=0x00, in_break=1 -> out_break=1 only on that entry, and ordering is preserved across the wrap.
- Overflow clear collision: with overflow=1, assert overflow_clear -> overflow=0. Then cause a drop and overflow_clear in the same cycle -> overflow=1.
- Reset mid-operation: with count=5 and overflow=1, pulse reset for 1 cycle -> all outputs return to reset values immediately. A following push of 0x7E is read out as the sole entry.
